// File: rtl/dlne_wr_seq.sv
// Write sequencer for a bank of DLNE latches: setup -> open -> hold strobes per accepted write.
// All outputs registered; one request in flight, next one accepted on the final hold cycle.
module dlne_wr_seq #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 2,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              WR_VALID,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [WIDTH-1:0]  WR_DATA,
  output logic              WR_RDY,
  output logic [WIDTH-1:0]  D_OUT,
  output logic [DEPTH-1:0]  G_OUT,
  output logic [DEPTH-1:0]  CE_OUT,
  output logic              BUSY,
  output logic              WR_DONE,
  output logic              WR_ERR
);

  localparam int MAX_SO = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
  localparam int MAXC   = (MAX_SO > HOLD_CYC) ? MAX_SO : HOLD_CYC;
  localparam int CW     = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] OPEN_LD  = CW'(OPEN_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] OPEN  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             in_range;
  logic [DEPTH-1:0] sel;

  // WR_RDY is a register, so acceptance never loops back through WR_VALID.
  assign accept   = WR_VALID & WR_RDY;
  assign in_range = (32'(WR_ADDR) < 32'(DEPTH));

  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (32'(WR_ADDR) == 32'(i)) sel[i] = 1'b1;
    end
  end

  // CE_OUT doubles as the captured one-hot address for the whole sequence;
  // an out-of-range write leaves it zero so no strobe ever moves.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state   <= IDLE;
      cnt     <= '0;
      D_OUT   <= '0;
      G_OUT   <= '1;
      CE_OUT  <= '0;
      WR_RDY  <= 1'b1;
      BUSY    <= 1'b0;
      WR_DONE <= 1'b0;
      WR_ERR  <= 1'b0;
    end else begin
      WR_DONE <= 1'b0;
      WR_ERR  <= 1'b0;
      if (accept) begin
        state  <= SETUP;
        cnt    <= SETUP_LD;
        D_OUT  <= WR_DATA;
        CE_OUT <= sel;
        G_OUT  <= '1;
        BUSY   <= 1'b1;
        WR_RDY <= 1'b0;
        WR_ERR <= !in_range;
      end else begin
        case (state)
          SETUP: begin
            if (cnt == '0) begin
              state <= OPEN;
              cnt   <= OPEN_LD;
              G_OUT <= ~CE_OUT;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          OPEN: begin
            if (cnt == '0) begin
              state <= HOLD;
              cnt   <= HOLD_LD;
              G_OUT <= '1;
              if (HOLD_CYC == 1) begin
                WR_DONE <= 1'b1;
                WR_RDY  <= 1'b1;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          HOLD: begin
            if (cnt == '0) begin
              state  <= IDLE;
              CE_OUT <= '0;
              BUSY   <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
              if (cnt == CW'(1)) begin
                WR_DONE <= 1'b1;
                WR_RDY  <= 1'b1;
              end
            end
          end
          default: begin
            G_OUT  <= '1;
            CE_OUT <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dlne_wr_seq.sv
// Bench for dlne_wr_seq: vector table, multi-cycle corner sequences, random writes vs. reference model.
module tb_dlne_wr_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  // default instance
  logic       v0;
  logic [1:0] a0;
  logic [7:0] d0;
  logic       rdy0, busy0, done0, err0;
  logic [7:0] dout0;
  logic [3:0] g0, ce0;
  dlne_wr_seq u0 (.CLK(clk), .RESETN(rstn), .WR_VALID(v0), .WR_ADDR(a0), .WR_DATA(d0),
                  .WR_RDY(rdy0), .D_OUT(dout0), .G_OUT(g0), .CE_OUT(ce0), .BUSY(busy0),
                  .WR_DONE(done0), .WR_ERR(err0));

  // stretched timing instance
  logic       v1;
  logic [1:0] a1;
  logic [7:0] d1;
  logic       rdy1, busy1, done1, err1;
  logic [7:0] dout1;
  logic [3:0] g1, ce1;
  dlne_wr_seq #(.SETUP_CYC(2), .OPEN_CYC(3), .HOLD_CYC(2)) u1 (
    .CLK(clk), .RESETN(rstn), .WR_VALID(v1), .WR_ADDR(a1), .WR_DATA(d1),
    .WR_RDY(rdy1), .D_OUT(dout1), .G_OUT(g1), .CE_OUT(ce1), .BUSY(busy1),
    .WR_DONE(done1), .WR_ERR(err1));

  // three-word instance, address 3 is out of range
  logic       v2;
  logic [1:0] a2;
  logic [7:0] d2;
  logic       rdy2, busy2, done2, err2;
  logic [7:0] dout2;
  logic [2:0] g2, ce2;
  dlne_wr_seq #(.DEPTH(3)) u2 (
    .CLK(clk), .RESETN(rstn), .WR_VALID(v2), .WR_ADDR(a2), .WR_DATA(d2),
    .WR_RDY(rdy2), .D_OUT(dout2), .G_OUT(g2), .CE_OUT(ce2), .BUSY(busy2),
    .WR_DONE(done2), .WR_ERR(err2));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference for u0: a write occupies cycles 1..T after its accept edge,
  // the gate is low for cycles S+1..S+O, done/ready on cycle T.
  localparam int S0 = 1, O0 = 1, H0 = 1, T0 = S0 + O0 + H0;
  int         age;
  logic [1:0] m_addr;
  logic [7:0] m_last;
  logic [7:0] mem [4];
  logic [7:0] lq  [4];
  bit         chk_on;

  function automatic logic       e_rdy();  return (age == 0) || (age == T0); endfunction
  function automatic logic [3:0] e_ce();   return (age > 0) ? (4'b0001 << m_addr) : 4'b0000; endfunction
  function automatic logic [3:0] e_g();
    return (age > S0 && age <= S0 + O0) ? ~(4'b0001 << m_addr) : 4'b1111;
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    if (!rstn) begin
      age    = 0;
      m_last = 8'h00;
    end else if (v0 && e_rdy()) begin
      age      = 1;
      m_addr   = a0;
      m_last   = d0;
      mem[a0]  = d0;
    end else if (age == T0) begin
      age = 0;
    end else if (age > 0) begin
      age++;
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      if (ce0[i] === 1'b1 && g0[i] === 1'b0) lq[i] = dout0;
    if (chk_on) begin
      chk("m_d",    32'(dout0), 32'(m_last));
      chk("m_ce",   32'(ce0),   32'(e_ce()));
      chk("m_g",    32'(g0),    32'(e_g()));
      chk("m_rdy",  32'(rdy0),  32'(e_rdy()));
      chk("m_busy", 32'(busy0), 32'(age > 0));
      chk("m_done", 32'(done0), 32'(age == T0));
      chk("m_err",  32'(err0),  32'(0));
      if (done0 === 1'b1)
        for (int i = 0; i < 4; i++) chk("m_latch", 32'(lq[i]), 32'(mem[i]));
    end
  endtask

  typedef struct {
    logic       vld;
    logic [1:0] addr;
    logic [7:0] data;
    logic [7:0] e_d;
    logic [3:0] e_ce;
    logic [3:0] e_g;
    logic       e_rdy;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t vt [5];
  logic will;
  int   acc, tg0, tg3, multi, done_c, acc2_c;
  int   dload, gl, gfirst, dn, errn, errk, strobe_bad, done_n;
  logic [3:0] glow;
  int   nw, budget;

  initial begin
    rstn = 1'b0;
    v0 = 0; a0 = 0; d0 = 0;
    v1 = 0; a1 = 0; d1 = 0;
    v2 = 0; a2 = 0; d2 = 0;
    age = 0; m_last = 0; m_addr = 0; chk_on = 0;
    for (int i = 0; i < 4; i++) begin
      lq[i]  = 8'($urandom);
      mem[i] = lq[i];
    end

    vt[0] = '{1'b0, 2'd0, 8'h00, 8'h00, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0};
    vt[1] = '{1'b1, 2'd2, 8'hA5, 8'hA5, 4'b0100, 4'b1111, 1'b0, 1'b1, 1'b0};
    vt[2] = '{1'b0, 2'd0, 8'h00, 8'hA5, 4'b0100, 4'b1011, 1'b0, 1'b1, 1'b0};
    vt[3] = '{1'b0, 2'd0, 8'h00, 8'hA5, 4'b0100, 4'b1111, 1'b1, 1'b1, 1'b1};
    vt[4] = '{1'b0, 2'd0, 8'h00, 8'hA5, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0};

    repeat (3) step();
    rstn = 1'b1;
    repeat (5) step();

    // single default write, table driven
    for (int k = 0; k < 5; k++) begin
      v0 = vt[k].vld; a0 = vt[k].addr; d0 = vt[k].data;
      step();
      chk("tbl_d",    32'(dout0), 32'(vt[k].e_d));
      chk("tbl_ce",   32'(ce0),   32'(vt[k].e_ce));
      chk("tbl_g",    32'(g0),    32'(vt[k].e_g));
      chk("tbl_rdy",  32'(rdy0),  32'(vt[k].e_rdy));
      chk("tbl_busy", 32'(busy0), 32'(vt[k].e_busy));
      chk("tbl_done", 32'(done0), 32'(vt[k].e_done));
      chk("tbl_err",  32'(err0),  32'(0));
    end
    v0 = 0;
    chk("tbl_latch2", 32'(lq[2]), 32'(8'hA5));

    // back-to-back writes with valid held
    v0 = 1; a0 = 0; d0 = 8'h11; acc = 0; tg0 = -1; tg3 = -1; multi = 0; done_c = -1; acc2_c = -1;
    for (int k = 0; k < 12; k++) begin
      will = v0 && rdy0;
      step();
      if (will) begin
        acc++;
        if (acc == 1) begin a0 = 3; d0 = 8'h33; end
        else begin v0 = 0; acc2_c = cyc; end
      end
      if (g0[0] === 1'b0 && tg0 < 0) tg0 = cyc;
      if (g0[3] === 1'b0 && tg3 < 0) tg3 = cyc;
      if (done0 === 1'b1 && done_c < 0) done_c = cyc;
      if ($countones(ce0) > 1) multi++;
    end
    chk("b2b_accepts", 32'(acc), 32'(2));
    chk("b2b_gate_gap", 32'(tg3 - tg0), 32'(3));
    chk("b2b_accept_at_done", 32'(acc2_c - done_c), 32'(1));
    chk("b2b_ce_onehot", 32'(multi), 32'(0));
    chk("b2b_latch0", 32'(lq[0]), 32'(8'h11));
    chk("b2b_latch3", 32'(lq[3]), 32'(8'h33));

    // stretched timing 2/3/2
    v1 = 1; a1 = 1; d1 = 8'h5A;
    step();
    v1 = 0;
    dload = -1; gl = 0; gfirst = -1; dn = -1; glow = 4'hF;
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) step();
      if (dout1 === 8'h5A && dload < 0) dload = k;
      if (g1 !== 4'hF) begin gl++; glow = g1; if (gfirst < 0) gfirst = k; end
      if (done1 === 1'b1 && dn < 0) dn = k;
    end
    chk("s2_dload", 32'(dload), 32'(1));
    chk("s2_gate_cycles", 32'(gl), 32'(3));
    chk("s2_gate_after_d", 32'(gfirst - dload), 32'(2));
    chk("s2_gate_bit", 32'(glow), 32'(4'b1101));
    chk("s2_done_at", 32'(dn), 32'(7));
    chk("s2_idle_after", 32'(busy1), 32'(0));

    // out-of-range address on a three-word bank
    v2 = 1; a2 = 3; d2 = 8'hC3;
    step();
    v2 = 0;
    errn = 0; errk = -1; done_n = -1; strobe_bad = 0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) step();
      if (err2 === 1'b1) begin errn++; if (errk < 0) errk = k; end
      if (done2 === 1'b1 && done_n < 0) done_n = k;
      if (g2 !== 3'b111 || ce2 !== 3'b000) strobe_bad++;
      if (k == 1) chk("oor_busy", 32'(busy2), 32'(1));
    end
    chk("oor_err_count", 32'(errn), 32'(1));
    chk("oor_err_at", 32'(errk), 32'(1));
    chk("oor_done_at", 32'(done_n), 32'(3));
    chk("oor_no_strobe", 32'(strobe_bad), 32'(0));

    // reset during the open cycle
    v0 = 1; a0 = 1; d0 = 8'h77;
    step();
    v0 = 0;
    step();
    chk("rst_in_open", 32'(g0), 32'(4'b1101));
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("rst_g",    32'(g0),    32'(4'hF));
    chk("rst_ce",   32'(ce0),   32'(0));
    chk("rst_d",    32'(dout0), 32'(0));
    chk("rst_rdy",  32'(rdy0),  32'(1));
    chk("rst_busy", 32'(busy0), 32'(0));
    done_n = 0; errn = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (done0 === 1'b1) done_n++;
      if (err0 === 1'b1) errn++;
    end
    chk("rst_no_done", 32'(done_n), 32'(0));
    chk("rst_no_err", 32'(errn), 32'(0));

    // random writes against the reference model and latch bank
    chk_on = 1;
    nw = 0; budget = 0;
    while (nw < 100 && budget < 2000) begin
      v0 = ($urandom_range(0, 3) != 0);
      a0 = 2'($urandom);
      d0 = 8'($urandom);
      will = v0 && rdy0;
      step();
      if (will) nw++;
      budget++;
    end
    v0 = 0;
    repeat (4) step();
    chk("rnd_writes", 32'(nw), 32'(100));
    for (int i = 0; i < 4; i++) chk("rnd_latch_final", 32'(lq[i]), 32'(mem[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
